// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
// Module : rom_pkg
// Brief  : Shared defaults and FSM state encoding for the ROM burst reader.
// Rev    : 1.0  initial release
// ============================================================================
package rom_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_reader_if.sv
`default_nettype none
// ============================================================================
// Module : rom_reader_if
// Brief  : Control, ROM-side and stream-side signals of the ROM burst reader.
// Rev    : 1.0  initial release
// ============================================================================
interface rom_reader_if
  import rom_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEFAULT_DEPTH)
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;

  logic                  rom_cs;
  logic                  rom_re;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0]      rom_data;

  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  // The reader itself
  modport slave (
    input  start, start_addr, length, rom_data, out_ready,
    output busy, done, rom_cs, rom_re, rom_addr, out_data, out_valid
  );

  // The environment: requester, ROM and stream sink
  modport master (
    output start, start_addr, length, rom_data, out_ready,
    input  busy, done, rom_cs, rom_re, rom_addr, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/rom_reader_buf.sv
`default_nettype none
// ============================================================================
// Module : rom_reader_buf
// Brief  : Two-entry output buffer; head entry drives the stream directly.
// Rev    : 1.0  initial release
// ============================================================================
module rom_reader_buf
  import rom_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_pop,
  output logic      [1:0]       o_count,
  output logic      [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // The head only changes on a pop or when filling an empty buffer,
  // which keeps the stream data stable while it is being stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= i_push_data;
          end else begin
            r_tail <= i_push_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_data  = r_head;

endmodule
`default_nettype wire

// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module : rom_reader
// Brief  : Streams a burst of words from a registered-read ROM with flow control.
// Rev    : 1.0  initial release
// ============================================================================
module rom_reader
  import rom_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  wire logic   clk,
  input  wire logic   reset,
  rom_reader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_left;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_count;
  logic [WIDTH-1:0]      w_data;
  logic                  w_pop;
  logic [2:0]            w_occupancy;
  logic                  w_issue;
  logic                  w_drain_empty;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  assign w_pop = (w_count != 2'd0) && bus.out_ready;

  // Words already buffered or on their way, after this cycle's pop; a new
  // read is only safe while that total leaves room in the two-entry buffer.
  assign w_occupancy   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue       = (r_state == ST_RUN) && (w_occupancy < 3'd2);
  assign w_drain_empty = !r_inflight && (w_count == {1'b0, w_pop});
  assign w_addr_next   = (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= 1'b0;
      if (w_issue) begin
        r_addr <= w_addr_next;
        r_left <= r_left - c_ONE_WORD;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              r_addr  <= bus.start_addr;
              r_left  <= bus.length;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_issue && (r_left == c_ONE_WORD)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data returns one cycle after the request, so the in-flight flag
  // doubles as the buffer push strobe.
  rom_reader_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data (bus.rom_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_data      (w_data)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rom_cs    = w_issue;
  assign bus.rom_re    = w_issue;
  assign bus.rom_addr  = r_addr;
  assign bus.out_data  = w_data;
  assign bus.out_valid = (w_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_rom_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_rom_reader
// Brief  : Directed table-driven bench for rom_reader with a one-hot ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rom_reader;
  import rom_pkg::*;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rom_reader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  rom_reader #(
    .WIDTH      (W),
    .DEPTH      (D),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Registered-read ROM holding word i = 1 << i
  logic [W-1:0] rom_mem [D];
  logic [W-1:0] rom_q = '0;
  initial for (int i = 0; i < D; i++) rom_mem[i] = W'(1) << i;
  always @(posedge clk) if (bus.rom_cs && bus.rom_re) rom_q <= rom_mem[bus.rom_addr];
  assign bus.rom_data = rom_q;

  typedef struct packed {
    logic [2:0]      addr;
    logic [3:0]      len;
    logic [3:0]      pat;       // out_ready for cycle k is pat[k % 4]
    logic [4:0]      inj;       // nonzero: stray start pulse at that cycle
    logic [7:0][7:0] beats_exp; // element 0 is the first expected beat
  } vec_t;

  vec_t vecs [7];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n = 0, issued = 0, first_v = -1, last_b = -1, done_k = -1, ndone = 0;
    int max_out = 0, addr_err = 0, re_err = 0, hold_err = 0, busy_err = 0, busy0 = 0;
    logic [7:0] beats [8];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = v.addr;
    bus.length     = v.len;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.start      = (v.inj != 5'd0) && (k == int'(v.inj));
      bus.start_addr = 3'd5;
      bus.length     = 4'd8;
      bus.out_ready  = v.pat[k % 4];
      @(negedge clk);
      if (k == 0) busy0 = int'(bus.busy);
      if (bus.rom_re != bus.rom_cs) re_err++;
      if (bus.rom_cs) begin
        if (bus.rom_addr != 3'(int'(v.addr) + issued)) addr_err++;
        issued++;
      end
      if (prev_hold && (!bus.out_valid || bus.out_data != prev_data)) hold_err++;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && first_v < 0) first_v = k;
      if (bus.out_valid && bus.out_ready) begin
        if (n < 8) beats[n] = bus.out_data;
        n++;
        last_b = k;
      end
      if (issued - n > max_out) max_out = issued - n;
      if (bus.done) begin
        ndone++;
        done_k = k;
        if (bus.busy) busy_err++;
      end
    end
    chk($sformatf("v%0d_beat_count", id), n, int'(v.len));
    for (int i = 0; i < int'(v.len) && i < n; i++)
      chk($sformatf("v%0d_beat%0d", id, i), int'(beats[i]), int'(v.beats_exp[i]));
    chk($sformatf("v%0d_reads_issued", id), issued, int'(v.len));
    chk($sformatf("v%0d_rom_addr_seq_errs", id), addr_err, 0);
    chk($sformatf("v%0d_rom_re_ne_cs", id), re_err, 0);
    chk($sformatf("v%0d_done_pulses", id), ndone, 1);
    chk($sformatf("v%0d_busy_with_done", id), busy_err, 0);
    chk($sformatf("v%0d_busy_first_cycle", id), busy0, (v.len != 0) ? 1 : 0);
    if (v.len == 4'd0) begin
      chk($sformatf("v%0d_done_cycle", id), done_k, 0);
      chk($sformatf("v%0d_first_valid", id), first_v, -1);
    end else begin
      chk($sformatf("v%0d_done_after_last_beat", id), (done_k > last_b) ? 1 : 0, 1);
      chk($sformatf("v%0d_first_valid", id), first_v, 2);
      chk($sformatf("v%0d_max_outstanding_le2", id), (max_out <= 2) ? 1 : 0, 1);
      chk($sformatf("v%0d_hold_errs", id), hold_err, 0);
      if (v.pat == 4'hF)
        chk($sformatf("v%0d_back_to_back", id), last_b - first_v, int'(v.len) - 1);
    end
    chk($sformatf("v%0d_idle_busy", id), int'(bus.busy), 0);
    chk($sformatf("v%0d_idle_valid", id), int'(bus.out_valid), 0);
  endtask

  initial begin
    vec_t rv;
    int   nb;

    vecs[0] = '{addr: 3'd0, len: 4'd8, pat: 4'b1111, inj: 5'd0,
                beats_exp: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
    vecs[1] = '{addr: 3'd6, len: 4'd4, pat: 4'b1111, inj: 5'd0,
                beats_exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h80, 8'h40}};
    vecs[2] = '{addr: 3'd0, len: 4'd8, pat: 4'b1001, inj: 5'd0,
                beats_exp: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
    vecs[3] = '{addr: 3'd0, len: 4'd0, pat: 4'b1111, inj: 5'd0,
                beats_exp: 64'h0};
    vecs[4] = '{addr: 3'd3, len: 4'd1, pat: 4'b1111, inj: 5'd0,
                beats_exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08}};
    vecs[5] = '{addr: 3'd7, len: 4'd8, pat: 4'b0110, inj: 5'd0,
                beats_exp: {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80}};
    vecs[6] = '{addr: 3'd0, len: 4'd8, pat: 4'b1111, inj: 5'd4,
                beats_exp: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};

    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b1;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      int'(bus.busy),      0);
    chk("reset_done",      int'(bus.done),      0);
    chk("reset_rom_cs",    int'(bus.rom_cs),    0);
    chk("reset_rom_addr",  int'(bus.rom_addr),  0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data",  int'(bus.out_data),  0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset three beats into an 8-word burst, with start asserted alongside
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = 3'd0;
    bus.length     = 4'd8;
    bus.out_ready  = 1'b1;
    nb = 0;
    for (int k = 0; k < 20 && nb < 3; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) nb++;
    end
    chk("rst_mid_beats_before", nb, 3);
    @(posedge clk); #1;
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 3'd5;
    bus.length     = 4'd3;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",      int'(bus.busy),      0);
    chk("rst_mid_done",      int'(bus.done),      0);
    chk("rst_mid_rom_cs",    int'(bus.rom_cs),    0);
    chk("rst_mid_rom_re",    int'(bus.rom_re),    0);
    chk("rst_mid_rom_addr",  int'(bus.rom_addr),  0);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_out_data",  int'(bus.out_data),  0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_late_capture", int'(bus.out_valid), 0);
    chk("rst_mid_start_ignored",   int'(bus.busy),      0);

    rv = '{addr: 3'd2, len: 4'd2, pat: 4'b1111, inj: 5'd0,
           beats_exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h04}};
    run_vec(rv, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
